// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite read definitions: response codes, bus FSM encoding,
// default protection bits and a counter-width helper.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] ARPROT_DEFAULT = 3'b000;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10
  } bus_state_t;

  // Bits needed to count from 0 up to n inclusive (at least 1).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/axi_lite_read_master_if.sv
// Command/result port and AXI4-Lite read channels of the read initiator.
// The master modport is the initiator's view; the slave modport is the
// view of whatever sits on the other side (local logic plus the AXI slave).
interface axi_lite_read_master_if #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH          = 16
);

  logic                          cmd_valid;
  logic                          cmd_ready;
  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr;

  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [C_M_AXI_DATA_WIDTH-1:0] rsp_data;
  logic [1:0]                    rsp_resp;
  logic                          rsp_timeout;

  logic [CNT_WIDTH-1:0]          txn_count;

  logic                          M_AXI_ARVALID;
  logic                          M_AXI_ARREADY;
  logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR;
  logic [2:0]                    M_AXI_ARPROT;

  logic                          M_AXI_RVALID;
  logic                          M_AXI_RREADY;
  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA;
  logic [1:0]                    M_AXI_RRESP;

  modport master (
    input  cmd_valid, cmd_addr, rsp_ready,
    input  M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RDATA, M_AXI_RRESP,
    output cmd_ready, rsp_valid, rsp_data, rsp_resp, rsp_timeout, txn_count,
    output M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_RREADY
  );

  modport slave (
    output cmd_valid, cmd_addr, rsp_ready,
    output M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RDATA, M_AXI_RRESP,
    input  cmd_ready, rsp_valid, rsp_data, rsp_resp, rsp_timeout, txn_count,
    input  M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_RREADY
  );

endinterface

// File: rtl/axi_lite_rd_timeout.sv
// Transaction timeout counter. Cleared on command accept, counts while
// enabled, and flags expiry in the cycle the count would reach
// TIMEOUT_CYCLES, so the abort result becomes visible one cycle later.
// TIMEOUT_CYCLES = 0 removes the counter entirely.
module axi_lite_rd_timeout
  import axi_lite_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  if (TIMEOUT_CYCLES > 0) begin : g_cnt
    localparam int unsigned     CW   = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]   LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_count;

    // Cycle counter: clear has priority over counting.
    always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_clear) begin
        r_count <= '0;
      end else if (i_enable) begin
        r_count <= r_count + CW'(1);
      end
    end

    assign o_expire = i_enable && (r_count == LAST);
  end else begin : g_none
    logic w_unused;
    assign w_unused = ^{i_clk, i_rst_n, i_clear, i_enable};
    assign o_expire = 1'b0;
  end

endmodule

// File: rtl/axi_lite_read_master.sv
// AXI4-Lite read initiator: accepts one read command at a time, runs the
// AR then R handshakes, and holds data/response/timeout on a result port
// until consumed. A timed-out transaction still completes on the bus; its
// late R beat is drained and discarded.
module axi_lite_read_master
  import axi_lite_pkg::*;
#(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES     = 1024,
  parameter int unsigned CNT_WIDTH          = 16
) (
  input  logic                    M_AXI_ACLK,
  input  logic                    M_AXI_ARESETN,
  axi_lite_read_master_if.master  bus
);

  bus_state_t                    r_state, w_state_nxt;
  logic [C_M_AXI_ADDR_WIDTH-1:0] r_araddr, w_araddr_nxt;
  logic                          r_cmd_ready, w_cmd_ready_nxt;
  logic                          r_rsp_valid, w_rsp_valid_nxt;
  logic [C_M_AXI_DATA_WIDTH-1:0] r_rsp_data, w_rsp_data_nxt;
  logic [1:0]                    r_rsp_resp, w_rsp_resp_nxt;
  logic                          r_rsp_timeout, w_rsp_timeout_nxt;
  logic                          r_abandon, w_abandon_nxt;
  logic [CNT_WIDTH-1:0]          r_txn_count, w_txn_count_nxt;

  logic w_accept;
  logic w_r_hs;
  logic w_to_enable;
  logic w_expire;

  assign w_accept    = bus.cmd_valid && r_cmd_ready;
  assign w_r_hs      = (r_state == DATA) && bus.M_AXI_RVALID;
  assign w_to_enable = (r_state != IDLE) && !r_abandon;

  axi_lite_rd_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk    (M_AXI_ACLK),
    .i_rst_n  (M_AXI_ARESETN),
    .i_clear  (w_accept),
    .i_enable (w_to_enable),
    .o_expire (w_expire)
  );

  // State and result registers; reset discards any in-flight transaction.
  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      r_state       <= IDLE;
      r_araddr      <= '0;
      r_cmd_ready   <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_resp    <= RESP_OKAY;
      r_rsp_timeout <= 1'b0;
      r_abandon     <= 1'b0;
      r_txn_count   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_araddr      <= w_araddr_nxt;
      r_cmd_ready   <= w_cmd_ready_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_data    <= w_rsp_data_nxt;
      r_rsp_resp    <= w_rsp_resp_nxt;
      r_rsp_timeout <= w_rsp_timeout_nxt;
      r_abandon     <= w_abandon_nxt;
      r_txn_count   <= w_txn_count_nxt;
    end
  end

  // Next-state, result capture and timeout abort decisions.
  always_comb begin
    w_state_nxt       = r_state;
    w_araddr_nxt      = r_araddr;
    w_rsp_valid_nxt   = r_rsp_valid;
    w_rsp_data_nxt    = r_rsp_data;
    w_rsp_resp_nxt    = r_rsp_resp;
    w_rsp_timeout_nxt = r_rsp_timeout;
    w_abandon_nxt     = r_abandon;
    w_txn_count_nxt   = r_txn_count;

    if (r_rsp_valid && bus.rsp_ready) begin
      w_rsp_valid_nxt = 1'b0;
    end

    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt  = ADDR;
          w_araddr_nxt = bus.cmd_addr;
        end
      end
      ADDR: begin
        if (bus.M_AXI_ARREADY) begin
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (bus.M_AXI_RVALID) begin
          w_state_nxt     = IDLE;
          w_abandon_nxt   = 1'b0;
          w_txn_count_nxt = r_txn_count + CNT_WIDTH'(1);
          if (!r_abandon) begin
            w_rsp_valid_nxt   = 1'b1;
            w_rsp_data_nxt    = bus.M_AXI_RDATA;
            w_rsp_resp_nxt    = bus.M_AXI_RRESP;
            w_rsp_timeout_nxt = 1'b0;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // A real R beat in the expiry cycle wins over the timeout abort.
    if (w_expire && !w_r_hs) begin
      w_abandon_nxt     = 1'b1;
      w_rsp_valid_nxt   = 1'b1;
      w_rsp_data_nxt    = '0;
      w_rsp_resp_nxt    = RESP_SLVERR;
      w_rsp_timeout_nxt = 1'b1;
    end

    w_cmd_ready_nxt = (w_state_nxt == IDLE) && !w_rsp_valid_nxt;
  end

  assign bus.cmd_ready     = r_cmd_ready;
  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.rsp_data      = r_rsp_data;
  assign bus.rsp_resp      = r_rsp_resp;
  assign bus.rsp_timeout   = r_rsp_timeout;
  assign bus.txn_count     = r_txn_count;
  assign bus.M_AXI_ARVALID = (r_state == ADDR);
  assign bus.M_AXI_ARADDR  = r_araddr;
  assign bus.M_AXI_ARPROT  = ARPROT_DEFAULT;
  assign bus.M_AXI_RREADY  = (r_state == DATA);

endmodule
